// File: rtl/click_pkg.sv
`default_nettype none
// ============================================================================
// Module   : click_pkg
// Purpose  : Shared state encoding and gesture codes for the click decoder.
// Revision : 1.0 - initial release
// ============================================================================
package click_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic COUNT = 1'b1;

  typedef enum logic {
    ST_IDLE  = IDLE,
    ST_COUNT = COUNT
  } state_t;

  localparam logic [1:0] GEST_SINGLE = 2'd1;
  localparam logic [1:0] GEST_DOUBLE = 2'd2;
  localparam logic [1:0] GEST_TRIPLE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/window_timer.sv
`default_nettype none
// ============================================================================
// Module   : window_timer
// Purpose  : Loadable down-counter measuring the gesture inactivity window.
// Revision : 1.0 - initial release
// ============================================================================
module window_timer #(
  parameter int WINDOW = 12_500_000,
  parameter int TW     = $clog2(WINDOW)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam logic [TW-1:0] C_LOAD = TW'(WINDOW - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= C_LOAD;
    end else if (en) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/click_decoder.sv
`default_nettype none
// ============================================================================
// Module   : click_decoder
// Purpose  : Groups press pulses into single/double/triple click events.
// Revision : 1.0 - initial release
// ============================================================================
import click_pkg::*;

module click_decoder #(
  parameter int WINDOW = 12_500_000,
  parameter int TW     = $clog2(WINDOW)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  output logic       single,
  output logic       double,
  output logic       triple,
  output logic       busy,
  output logic [1:0] click_cnt
);

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_single;
  logic       r_double;
  logic       r_triple;

  logic       w_timer_load;
  logic       w_timer_en;
  logic       w_timer_zero;

  // A third press closes the gesture, so the timer is only reloaded below that.
  always_comb begin
    w_timer_load = press & ((r_state == ST_IDLE) | (r_cnt != GEST_DOUBLE));
    w_timer_en   = (r_state == ST_COUNT) & ~press & ~w_timer_zero;
  end

  window_timer #(
    .WINDOW (WINDOW),
    .TW     (TW)
  ) u_window_timer (
    .clk   (clk),
    .reset (reset),
    .load  (w_timer_load),
    .en    (w_timer_en),
    .zero  (w_timer_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 2'd0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_triple <= 1'b0;
    end else begin
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_triple <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (press) begin
            r_cnt   <= GEST_SINGLE;
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          // Press outranks expiry so a press on the last window cycle is kept.
          if (press && (r_cnt == GEST_DOUBLE)) begin
            r_triple <= 1'b1;
            r_cnt    <= 2'd0;
            r_state  <= ST_IDLE;
          end else if (press) begin
            r_cnt <= r_cnt + 2'd1;
          end else if (w_timer_zero) begin
            r_single <= (r_cnt == GEST_SINGLE);
            r_double <= (r_cnt == GEST_DOUBLE);
            r_cnt    <= 2'd0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_cnt   <= 2'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign single    = r_single;
  assign double    = r_double;
  assign triple    = r_triple;
  assign busy      = (r_state == ST_COUNT);
  assign click_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_click_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_click_decoder
// Purpose  : Directed self-checking bench for click_decoder with WINDOW=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_click_decoder;

  localparam int WINDOW = 4;

  // Observed vector: {single, double, triple, busy, click_cnt[1:0]}
  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] B1 = 6'b000101;
  localparam logic [5:0] B2 = 6'b000110;
  localparam logic [5:0] S  = 6'b100000;
  localparam logic [5:0] D  = 6'b010000;
  localparam logic [5:0] T  = 6'b001000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       press = 1'b0;
  logic       single;
  logic       double;
  logic       triple;
  logic       busy;
  logic [1:0] click_cnt;
  logic [5:0] obs;

  int errors = 0;
  int checks = 0;

  click_decoder #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .reset     (reset),
    .press     (press),
    .single    (single),
    .double    (double),
    .triple    (triple),
    .busy      (busy),
    .click_cnt (click_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {single, double, triple, busy, click_cnt};

  // Drive press for one edge; return 1 time unit after that edge.
  task automatic step(input logic p);
    @(negedge clk);
    press = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== Z) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, Z);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [5:0] exp_v [8] = '{B1, B1, B1, B1, S, Z, Z, Z};
    for (int k = 0; k < 8; k++) begin
      step(k == 0);
      checks++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL single_k%0d: got %b expected %b", k, obs, exp_v[k]);
      end
    end
  endtask

  task automatic test_double();
    logic [5:0] exp_v [8] = '{B1, B1, B2, B2, B2, B2, D, Z};
    for (int k = 0; k < 8; k++) begin
      step(k == 0 || k == 2);
      checks++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL double_k%0d: got %b expected %b", k, obs, exp_v[k]);
      end
    end
  endtask

  task automatic test_triple();
    logic [5:0] exp_v [11] = '{B1, B2, B2, T, Z, B1, B1, B1, B1, S, Z};
    for (int k = 0; k < 11; k++) begin
      step(k == 0 || k == 1 || k == 3 || k == 5);
      checks++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL triple_k%0d: got %b expected %b", k, obs, exp_v[k]);
      end
    end
  endtask

  task automatic test_press_on_expiry();
    logic [5:0] exp_v [10] = '{B1, B1, B1, B1, B2, B2, B2, B2, D, Z};
    for (int k = 0; k < 10; k++) begin
      step(k == 0 || k == 4);
      checks++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL expiry_k%0d: got %b expected %b", k, obs, exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid_gesture();
    logic [5:0] exp_v [8] = '{B1, B1, B1, B1, S, Z, Z, Z};
    step(1'b1);
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== Z) begin
      errors++;
      $display("FAIL reset_mid_assert: got %b expected %b", obs, Z);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0);
      checks++;
      if (obs !== Z) begin
        errors++;
        $display("FAIL reset_mid_quiet_k%0d: got %b expected %b", k, obs, Z);
      end
    end
    for (int k = 0; k < 8; k++) begin
      step(k == 0);
      checks++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL reset_mid_single_k%0d: got %b expected %b", k, obs, exp_v[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_v [11] = '{B1, B1, B1, B1, S, B1, B1, B1, B1, S, Z};
    for (int k = 0; k < 11; k++) begin
      step(k == 0 || k == 5);
      checks++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL back_to_back_k%0d: got %b expected %b", k, obs, exp_v[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_triple();
    test_press_on_expiry();
    test_reset_mid_gesture();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/click_decoder.md
# click_decoder

Downstream consumer of the one-shot press pulse from the debounce/lockout stage. Groups press pulses that arrive within a programmable inactivity window into one gesture. Emits exactly one single-cycle event per gesture: single, double or triple click. Feeds UI/menu control logic, which needs gesture events rather than raw presses.

## Interface
- `WINDOW`, default 12_500_000: inactivity window in clk cycles (125 ms at 100 MHz); must be ≥ 2.
- `TW`, default $clog2(WINDOW): timer width in bits. Derived; not overridden independently.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high; clock clk.
- `press`  in  1  one-cycle press pulse from the upstream debouncer. Any high cycle counts as one press.
- `single`  out  1  one-cycle pulse; gesture ended with 1 press.
- `double`  out  1  one-cycle pulse; gesture ended with 2 presses.
- `triple`  out  1  one-cycle pulse; gesture reached 3 presses.
- `busy`  out  1  high while a gesture window is open.
- `click_cnt`  out  2  presses accumulated in the current gesture; 0 when idle.

## Operation
- FSM with two states: IDLE and COUNT. Registers: state, timer[TW-1:0], cnt[1:0], and the three event outputs.
- **IDLE**
  - When press=1: cnt←1, timer←WINDOW-1, state←COUNT.
- **COUNT**, with priority in this order:
  1. press=1 and cnt=2: triple←1, cnt←0, state←IDLE.
  2. press=1: cnt←cnt+1, timer←WINDOW-1. Press beats expiry when both occur in the same cycle.
  3. timer=0: single←(cnt=1), double←(cnt=2), cnt←0, state←IDLE.
  4. Otherwise: timer←timer-1.
- Event outputs are registered. Each is high for exactly one cycle and then returns to 0. At most one event output is high in any cycle.
- `busy` = (state==COUNT).
- `click_cnt` = cnt register.
- A press in the cycle an event is high is sampled in IDLE and starts a new gesture. No press is lost.
- The timer never wraps: it is reloaded or the FSM leaves COUNT at 0.
- Unused state encodings go to IDLE with cnt←0.

## Timing
- Reset value of every output: single, double, triple, busy = 0; click_cnt = 0. Timer is 0 and state is IDLE.
- Reset asserted mid-gesture aborts the gesture. No event is emitted, during reset or after release.
- Press→busy: busy and click_cnt=1 go high on the edge that samples the first press.
- single/double latency: the event is high in the cycle after edge E+WINDOW, where E is the edge that sampled the last press.
- triple latency: high in the cycle after the edge that sampled the third press. No waiting for the window.
- Minimum gesture spacing: none. Back-to-back gestures are accepted with zero dead cycles.

## Structure
- Shared package `click_pkg`:
  - State encoding localparams: IDLE=1'b0, COUNT=1'b1.
  - Gesture code constants: 2'd1, 2'd2, 2'd3.
- Sub-module `window_timer(clk, reset, load, en, zero)`:
  - Loadable TW-bit down-counter, loads WINDOW-1.
  - `zero` is combinational from the counter register.
- The top level holds the FSM, cnt and event registers.

## Test plan
All scenarios use WINDOW=4.
- **Single press.** One press pulse at edge E → busy=1, click_cnt=1 after E. single=1 in exactly one cycle, after edge E+4. No double or triple. busy=0 afterwards.
- **Double press.** Presses 2 cycles apart, second at edge F → click_cnt=2. double=1 once, after edge F+4. single is never high.
- **Triple press.** Presses at E, E+1, E+3 → triple=1 in the cycle after E+3. No single or double. A fourth press at E+5 starts a new gesture and yields single after edge E+9.
- **Press on the expiry cycle.** Second press sampled in the cycle where timer=0 → counted, timer reloaded. double fires 4 edges later; single is never emitted.
- **Reset mid-gesture.** Reset pulsed 2 cycles after a press → all outputs 0 and busy=0. No event fires. A later single press behaves as in the single-press scenario.
- **Back-to-back gestures.** Press sampled in the cycle single is high → new gesture starts (busy=1, click_cnt=1). The next single fires 4 edges later.
